// File: rtl/awb_gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : awb_gain_sequencer
// Purpose  : Runs R/G/B white-balance gain divisions on one shared serial
//            divider. Results are committed as a set on a frame boundary.
//            Optional gain clamping is enabled by defining AWB_GAIN_CLAMP_EN.
// Revision : 1.0
// ============================================================================
module awb_gain_sequencer #(
    parameter int unsigned          PRECISION = 16,
    parameter int unsigned          TIMEOUT   = 64,
    parameter logic [PRECISION-1:0] GAIN_MIN  = PRECISION'(16'h0040),
    parameter logic [PRECISION-1:0] GAIN_MAX  = PRECISION'(16'h0400)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mean_valid_i,
    input  logic [7:0]           r_mean_i,
    input  logic [7:0]           g_mean_i,
    input  logic [7:0]           b_mean_i,
    input  logic                 frame_start_i,
    output logic                 div_start_o,
    output logic [15:0]          div_dividend_o,
    output logic [7:0]           div_divisor_o,
    input  logic                 div_done_i,
    input  logic [PRECISION-1:0] div_quot_i,
    output logic                 busy_o,
    output logic [PRECISION-1:0] K_R_o,
    output logic [PRECISION-1:0] K_G_o,
    output logic [PRECISION-1:0] K_B_o,
    output logic                 gain_update_o,
    output logic                 err_o
);

    localparam int unsigned          c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]   c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [PRECISION-1:0] c_UNITY   = PRECISION'(256);
    localparam logic [1:0]           c_CH_B    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_NEXT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_div_start;
    logic                  w_timeout;
    logic                  w_store;
    logic [1:0]            r_ch;
    logic [7:0]            r_mean_grn;
    logic [7:0]            r_mean_blu;
    logic [15:0]           r_div_dividend;
    logic [7:0]            r_div_divisor;
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic [PRECISION-1:0]  r_work    [3];
    logic [PRECISION-1:0]  r_pending [3];
    logic                  r_pending_valid;
    logic [PRECISION-1:0]  r_k_r, r_k_g, r_k_b;
    logic                  r_gain_update;
    logic                  r_err;
    logic [9:0]            w_sum;
    logic [7:0]            w_k_mean;
    logic [PRECISION-1:0]  w_quot_raw;
    logic [PRECISION-1:0]  w_work_din;
    logic                  w_commit;

    function automatic logic [PRECISION-1:0] sat_gain(input logic [PRECISION-1:0] q);
        if (q < GAIN_MIN) return GAIN_MIN;
        if (q > GAIN_MAX) return GAIN_MAX;
        return q;
    endfunction

    assign w_sum    = {2'b00, r_mean_i} + {2'b00, g_mean_i} + {2'b00, b_mean_i};
    assign w_k_mean = 8'(w_sum / 10'd3);

    // A zero divisor never reaches the divider; it saturates in REQ instead.
    assign w_quot_raw = (r_state == S_REQ) ? '1 : div_quot_i;
`ifdef AWB_GAIN_CLAMP_EN
    assign w_work_din = sat_gain(w_quot_raw);
`else
    assign w_work_din = w_quot_raw;
`endif

    assign w_commit = frame_start_i && r_pending_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_timeout   = 1'b0;
        w_store     = 1'b0;
        case (r_state)
            S_IDLE: if (mean_valid_i) w_state_nxt = S_REQ;
            S_REQ: begin
                if (r_div_divisor == 8'd0) begin
                    w_store     = 1'b1;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_div_start = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_done_i) begin
                    w_store     = 1'b1;
                    w_state_nxt = S_NEXT;
                end else if (r_wait_cnt == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_NEXT:  w_state_nxt = (r_ch != c_CH_B) ? S_REQ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch            <= 2'd0;
            r_mean_grn      <= 8'd0;
            r_mean_blu      <= 8'd0;
            r_div_dividend  <= 16'd0;
            r_div_divisor   <= 8'd0;
            r_wait_cnt      <= '0;
            r_pending_valid <= 1'b0;
            r_k_r           <= c_UNITY;
            r_k_g           <= c_UNITY;
            r_k_b           <= c_UNITY;
            r_gain_update   <= 1'b0;
            r_err           <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_work[i]    <= '0;
                r_pending[i] <= '0;
            end
        end else begin
            r_gain_update <= w_commit;
            // Commit consumes the previously registered pending set; a set
            // finishing in this same cycle re-arms pending_valid below.
            if (w_commit) begin
                r_k_r           <= r_pending[0];
                r_k_g           <= r_pending[1];
                r_k_b           <= r_pending[2];
                r_pending_valid <= 1'b0;
            end
            if (w_timeout) r_err <= 1'b1;
            if (w_store) begin
                for (int i = 0; i < 3; i++)
                    if (r_ch == 2'(i)) r_work[i] <= w_work_din;
            end
            case (r_state)
                S_IDLE: begin
                    if (mean_valid_i) begin
                        r_ch           <= 2'd0;
                        r_mean_grn     <= g_mean_i;
                        r_mean_blu     <= b_mean_i;
                        r_div_dividend <= {w_k_mean, 8'd0};
                        r_div_divisor  <= r_mean_i;
                    end
                end
                S_REQ:  r_wait_cnt <= '0;
                S_WAIT: r_wait_cnt <= r_wait_cnt + 1'b1;
                S_NEXT: begin
                    if (r_ch != c_CH_B) begin
                        r_ch          <= r_ch + 2'd1;
                        r_div_divisor <= (r_ch == 2'd0) ? r_mean_grn : r_mean_blu;
                    end else begin
                        for (int i = 0; i < 3; i++) r_pending[i] <= r_work[i];
                        r_pending_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_start_o    = w_div_start;
    assign div_dividend_o = r_div_dividend;
    assign div_divisor_o  = r_div_divisor;
    assign busy_o         = (r_state != S_IDLE);
    assign K_R_o          = r_k_r;
    assign K_G_o          = r_k_g;
    assign K_B_o          = r_k_b;
    assign gain_update_o  = r_gain_update;
    assign err_o          = r_err;

endmodule
`default_nettype wire
